cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Control-step sequencer for the basic 9-bit CPU.
- Drives the instruction register load enable and all datapath enables: register file in/out, bus source select, A/G latches and add/sub.
- Decodes the IR output, with format III_XXX_YYY (opcode, destination Rx, source Ry).
- Sequences each instruction over control steps T0..T3 and signals completion.

Parameters:
- REG_IDX_W, 3, register index width; register count = 2**REG_IDX_W; instruction width = 3 + 2*REG_IDX_W (9 at default).

Ports:
- iClk  input  1  rising-edge clock
- iRst_n  input  1  asynchronous active-low reset
- iRun  input  1  start/continue execution request
- iIns  input  3+2*REG_IDX_W  IR output (instruction currently held)
- oIRin  output  1  IR load enable
- oRin  output  2**REG_IDX_W  one-hot register-file write enables
- oRout  output  2**REG_IDX_W  one-hot register-file bus drive enables
- oDINout  output  1  external data (DIN) drives bus
- oGout  output  1  G register drives bus
- oAin  output  1  A register load
- oGin  output  1  G register load (ALU result)
- oAddSub  output  1  0 = add, 1 = subtract
- oDone  output  1  instruction complete (one-cycle pulse)
- oStep  output  2  current control step (0 = T0 .. 3 = T3)
- oIllegal  output  1  illegal-opcode flag

Behaviour:
- Reset:
  - Asynchronous, active-low; the state register clears immediately to T0.
  - While iRst_n = 0, every output is forced to 0, including oIRin and oStep = 0.
  - Reset mid-instruction aborts it; no partial enables persist after release.
- State register: the only sequential element. All outputs are combinational decodes of state, iIns and iRun. Bus enables are mutually exclusive in every step.
- Opcode decode is on iIns[8:6]; X = iIns[5:3], Y = iIns[2:0] (default widths). iIns is trusted only in T1..T3, because the IR loads at the end of T0.
- T0 (fetch):
  - oIRin = iRun.
  - iRun = 1 -> T1; else stay in T0. No other enables.
- T1:
  - 000 mv: oRout[Y] = 1, oRin[X] = 1, oDone = 1 -> T0.
  - 001 mvi: oDINout = 1, oRin[X] = 1, oDone = 1 -> T0.
  - 010 add / 011 sub: oRout[X] = 1, oAin = 1 -> T2.
  - 1xx: see Optional Feature.
- T2 (add/sub only): oRout[Y] = 1, oGin = 1, oAddSub = (opcode == 011) -> T3.
- T3 (add/sub only): oGout = 1, oRin[X] = 1, oDone = 1 -> T0.
- Latency:
  - mv/mvi = 2 cycles (T0, T1); add/sub = 4 cycles.
  - Back-to-back instructions need no idle cycle: T0 follows oDone directly, and oIRin reasserts there if iRun is high.
- X == Y is legal; for mv it is a self-copy. For add/sub the same register is both driven and written in distinct steps.
- iRun is sampled only in T0. Deassertion during T1..T3 does not stall or abort the instruction.
- oDone is high for exactly one cycle per completed instruction, never in T0.
- oStep mirrors the state encoding T0 = 0, T1 = 1, T2 = 2, T3 = 3.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Opcode 1xx in T1 enters a HALT state: no datapath enables, oIRin = 0, oDone = 0.
  - oIllegal = 1 is held continuously and oStep = 3.
  - iRun is ignored; exit from HALT is only via iRst_n.
- Undefined:
  - Opcode 1xx executes as a NOP: T1 asserts oDone only, then -> T0.
  - oIllegal is tied to 0; the HALT state does not exist.

Test Plan:
1. Reset, then iRun = 1 with iIns = 9'h040 after the T0 edge (mvi R0) -> T0: oIRin = 1; T1: oDINout = 1, oRin = 8'h01, oDone = 1; back in T0 the next cycle.
2. iIns = 9'h008 (mv R1,R0) -> T1: oRout = 8'h01, oRin = 8'h02, oDone = 1; 2-cycle total. A following instruction shows oIRin = 1 in the very next cycle.
3. iIns = 9'h081 (add R0,R1) ->
   - T1: oRout = 8'h01, oAin = 1.
   - T2: oRout = 8'h02, oGin = 1, oAddSub = 0.
   - T3: oGout = 1, oRin = 8'h01, oDone = 1.
4. iIns = 9'h0C8 (sub R1,R0) -> T2: oRout = 8'h01, oAddSub = 1. T3: oRin = 8'h02, oDone = 1. iRun dropped in T2 has no effect.
5. Assert iRst_n = 0 asynchronously in T2 of an add -> all outputs 0 immediately, with no clock edge needed. After release with iRun = 0: stays in T0, oStep = 0, no oDone.
6. iIns = 9'h100 -> trap build: oIllegal = 1 held, and toggling iRun does not restart fetch until reset. Non-trap build: T1 oDone = 1 only, oIllegal = 0, returns to T0.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Control-step sequencer for the basic 9-bit CPU: fetch in T0, execute mv/mvi/add/sub over T1..T3.
// Define CTRL_ILLEGAL_TRAP_EN to trap opcode 1xx into a HALT state (otherwise it executes as a NOP).
`timescale 1ns/1ps
module cpu_ctrl_fsm #(
  parameter int REG_IDX_W = 3,
  localparam int NREG     = 2**REG_IDX_W,
  localparam int INS_W    = 3 + 2*REG_IDX_W
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iRun,
  input  logic [INS_W-1:0] iIns,
  output logic             oIRin,
  output logic [NREG-1:0]  oRin,
  output logic [NREG-1:0]  oRout,
  output logic             oDINout,
  output logic             oGout,
  output logic             oAin,
  output logic             oGin,
  output logic             oAddSub,
  output logic             oDone,
  output logic [1:0]       oStep,
  output logic             oIllegal
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {S_T0 = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3, S_HALT = 3'd4} state_t;
`else
  typedef enum logic [1:0] {S_T0 = 2'd0, S_T1 = 2'd1, S_T2 = 2'd2, S_T3 = 2'd3} state_t;
`endif

  state_t state_q, state_d;

  logic [2:0]           opc;
  logic [REG_IDX_W-1:0] rx, ry;
  logic [NREG-1:0]      oh_x, oh_y;
  logic                 ir_in, din_out, g_out, a_in, g_in, add_sub, done, illegal;
  logic [NREG-1:0]      r_in, r_out;
  logic [1:0]           step;

  assign opc  = iIns[INS_W-1 -: 3];
  assign rx   = iIns[2*REG_IDX_W-1 -: REG_IDX_W];
  assign ry   = iIns[REG_IDX_W-1:0];
  assign oh_x = NREG'(1) << rx;
  assign oh_y = NREG'(1) << ry;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= S_T0;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ir_in   = 1'b0;
    r_in    = '0;
    r_out   = '0;
    din_out = 1'b0;
    g_out   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    add_sub = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_T0: begin
        ir_in = iRun;
        if (iRun) state_d = S_T1;
      end
      S_T1: begin
        case (opc)
          3'b000: begin
            r_out   = oh_y;
            r_in    = oh_x;
            done    = 1'b1;
            state_d = S_T0;
          end
          3'b001: begin
            din_out = 1'b1;
            r_in    = oh_x;
            done    = 1'b1;
            state_d = S_T0;
          end
          3'b010, 3'b011: begin
            r_out   = oh_x;
            a_in    = 1'b1;
            state_d = S_T2;
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            done    = 1'b1;
            state_d = S_T0;
`endif
          end
        endcase
      end
      S_T2: begin
        r_out   = oh_y;
        g_in    = 1'b1;
        add_sub = (opc == 3'b011);
        state_d = S_T3;
      end
      S_T3: begin
        g_out   = 1'b1;
        r_in    = oh_x;
        done    = 1'b1;
        state_d = S_T0;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      // Only reset leaves HALT.
      S_HALT: illegal = 1'b1;
`endif
      default: state_d = S_T0;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign step = (state_q == S_HALT) ? 2'd3 : state_q[1:0];
`else
  assign step = state_q;
`endif

  // Outputs are forced low while reset is held, even the iRun-driven IR load.
  assign oIRin    = iRst_n & ir_in;
  assign oRin     = {NREG{iRst_n}} & r_in;
  assign oRout    = {NREG{iRst_n}} & r_out;
  assign oDINout  = iRst_n & din_out;
  assign oGout    = iRst_n & g_out;
  assign oAin     = iRst_n & a_in;
  assign oGin     = iRst_n & g_in;
  assign oAddSub  = iRst_n & add_sub;
  assign oDone    = iRst_n & done;
  assign oStep    = {2{iRst_n}} & step;
  assign oIllegal = iRst_n & illegal;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Table-driven bench for cpu_ctrl_fsm with a scoreboard queue of expected output vectors.
`timescale 1ns/1ps
module tb_cpu_ctrl_fsm;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iRun = 1'b0;
  logic [8:0] iIns = '0;
  logic       oIRin, oDINout, oGout, oAin, oGin, oAddSub, oDone, oIllegal;
  logic [7:0] oRin, oRout;
  logic [1:0] oStep;

  cpu_ctrl_fsm #(.REG_IDX_W(3)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iRun(iRun), .iIns(iIns),
    .oIRin(oIRin), .oRin(oRin), .oRout(oRout), .oDINout(oDINout),
    .oGout(oGout), .oAin(oAin), .oGin(oGin), .oAddSub(oAddSub),
    .oDone(oDone), .oStep(oStep), .oIllegal(oIllegal)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       din, gout, ain, gin, addsub, done;
    logic [1:0] step;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic       run;
    logic [8:0] ins;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic out_t o(logic irin, logic [7:0] rin, logic [7:0] rout, logic din, logic gout,
                             logic ain, logic gin, logic as, logic done, logic [1:0] step, logic ill);
    out_t r;
    r = '{irin, rin, rout, din, gout, ain, gin, as, done, step, ill};
    return r;
  endfunction

  function automatic out_t idle(logic [1:0] step);
    return o(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, step, 0);
  endfunction

  function automatic out_t actual();
    out_t r;
    r = '{oIRin, oRin, oRout, oDINout, oGout, oAin, oGin, oAddSub, oDone, oStep, oIllegal};
    return r;
  endfunction

  task automatic check(input string name);
    out_t e, a;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      a = actual();
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got %h required %h", name, a, e);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    iRun = v.run;
    iIns = v.ins;
    sb.push_back(v.exp);
    @(negedge iClk);
    check(name);
    @(posedge iClk);
    #1;
  endtask

  task automatic add_vec(input logic run, input logic [8:0] ins, input out_t e);
    vec_t v;
    v = '{run, ins, e};
    vecs.push_back(v);
  endtask

  initial begin
    // mvi R0, then mv R1,R0 back to back
    add_vec(1, 9'h040, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add_vec(0, 9'h040, o(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1, 0));
    add_vec(1, 9'h008, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add_vec(1, 9'h008, o(0, 8'h02, 8'h01, 0, 0, 0, 0, 0, 1, 2'd1, 0));
    // add R0,R1
    add_vec(1, 9'h081, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add_vec(1, 9'h081, o(0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0, 2'd1, 0));
    add_vec(1, 9'h081, o(0, 8'h00, 8'h02, 0, 0, 0, 1, 0, 0, 2'd2, 0));
    add_vec(1, 9'h081, o(0, 8'h01, 8'h00, 0, 1, 0, 0, 0, 1, 2'd3, 0));
    // sub R1,R0 with iRun dropped mid-instruction
    add_vec(1, 9'h0C8, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add_vec(1, 9'h0C8, o(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 2'd1, 0));
    add_vec(0, 9'h0C8, o(0, 8'h00, 8'h01, 0, 0, 0, 1, 1, 0, 2'd2, 0));
    add_vec(0, 9'h0C8, o(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1, 2'd3, 0));
    add_vec(0, 9'h0C8, idle(2'd0));
    add_vec(0, 9'h0C8, idle(2'd0));
    // mv R2,R2 self-copy
    add_vec(1, 9'h012, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add_vec(0, 9'h012, o(0, 8'h04, 8'h04, 0, 0, 0, 0, 0, 1, 2'd1, 0));
    // sub R7,R7 exercises top register index
    add_vec(1, 9'h0FF, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    add_vec(0, 9'h0FF, o(0, 8'h00, 8'h80, 0, 0, 1, 0, 0, 0, 2'd1, 0));
    add_vec(0, 9'h0FF, o(0, 8'h00, 8'h80, 0, 0, 0, 1, 1, 0, 2'd2, 0));
    add_vec(0, 9'h0FF, o(0, 8'h80, 8'h00, 0, 1, 0, 0, 0, 1, 2'd3, 0));

    // Reset state
    #2;
    sb.push_back(idle(2'd0));
    check("reset_state");
    @(posedge iClk); #1;
    iRun = 1'b1;
    sb.push_back(idle(2'd0));
    #1;
    check("reset_irin_gated");
    iRun = 1'b0;
    @(posedge iClk); #1;
    iRst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in T2 of an add
    apply('{1'b1, 9'h081, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 0)}, "rst_add_t0");
    apply('{1'b1, 9'h081, o(0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0, 2'd1, 0)}, "rst_add_t1");
    sb.push_back(o(0, 8'h00, 8'h02, 0, 0, 0, 1, 0, 0, 2'd2, 0));
    @(negedge iClk);
    check("rst_add_t2");
    #1;
    iRst_n = 1'b0;
    #1;
    sb.push_back(idle(2'd0));
    check("rst_async_clear");
    @(posedge iClk); #1;
    iRun = 1'b0;
    iRst_n = 1'b1;
    apply('{1'b0, 9'h081, idle(2'd0)}, "rst_release0");
    apply('{1'b0, 9'h081, idle(2'd0)}, "rst_release1");

    // Opcode 1xx
    apply('{1'b1, 9'h100, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 0)}, "ill_t0");
`ifdef CTRL_ILLEGAL_TRAP_EN
    apply('{1'b1, 9'h100, idle(2'd1)}, "ill_t1");
    apply('{1'b0, 9'h100, o(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd3, 1)}, "halt0");
    apply('{1'b1, 9'h100, o(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd3, 1)}, "halt1");
    apply('{1'b1, 9'h040, o(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd3, 1)}, "halt2");
`else
    apply('{1'b1, 9'h100, o(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1, 0)}, "nop_t1");
    apply('{1'b0, 9'h100, idle(2'd0)}, "nop_back_t0");
    apply('{1'b1, 9'h1C0, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 0)}, "nop2_t0");
    apply('{1'b0, 9'h1C0, o(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1, 0)}, "nop2_t1");
`endif
    iRst_n = 1'b0;
    #1;
    iRst_n = 1'b1;
    apply('{1'b1, 9'h040, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 0)}, "post_rst_t0");
    apply('{1'b0, 9'h040, o(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1, 0)}, "post_rst_t1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
